instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_if.sv | 33 +++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// ============================================================================
// Module   : instruction_fetch_unit_if
// Function : Fetch request, byte-ROM bus and result handshake bundle
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_unit_if;
  logic        start;
  logic [31:0] pc;
  logic [7:0]  rom_read_data;
  logic        rom_illegal_address;
  logic [31:0] rom_address;
  logic        rom_output_enable;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic        fetch_error;
  logic        busy;

  // master = the fetch unit itself; slave = requester/ROM side
  modport master (
    input  start, pc, rom_read_data, rom_illegal_address, out_ready,
    output rom_address, rom_output_enable, instruction, out_valid, fetch_error, busy
  );

  modport slave (
    output start, pc, rom_read_data, rom_illegal_address, out_ready,
    input  rom_address, rom_output_enable, instruction, out_valid, fetch_error, busy
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Function : Assembles a little-endian 32-bit word from four byte-ROM reads
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  wire                        clk,
  input  wire                        reset,
  instruction_fetch_unit_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ0 = 3'd1,
    READ1 = 3'd2,
    READ2 = 3'd3,
    READ3 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_base;
  logic [31:0] w_base_next;
  logic [31:0] r_instr;
  logic [31:0] w_instr_next;
  logic        r_error;
  logic        w_error_next;
  logic [1:0]  w_byte_idx;
  logic        w_reading;
  state_t      w_read_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_base  <= 32'h0;
      r_instr <= 32'h0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_base  <= w_base_next;
      r_instr <= w_instr_next;
      r_error <= w_error_next;
    end
  end

  // Byte lane and successor for the READn states
  always_comb begin
    w_byte_idx  = 2'd0;
    w_reading   = 1'b0;
    w_read_next = DONE;
    case (r_state)
      READ0:   begin w_byte_idx = 2'd0; w_reading = 1'b1; w_read_next = READ1; end
      READ1:   begin w_byte_idx = 2'd1; w_reading = 1'b1; w_read_next = READ2; end
      READ2:   begin w_byte_idx = 2'd2; w_reading = 1'b1; w_read_next = READ3; end
      READ3:   begin w_byte_idx = 2'd3; w_reading = 1'b1; w_read_next = DONE;  end
      default: begin w_byte_idx = 2'd0; w_reading = 1'b0; w_read_next = DONE;  end
    endcase
  end

  always_comb begin
    w_state_next          = r_state;
    w_base_next           = r_base;
    w_instr_next          = r_instr;
    w_error_next          = r_error;
    bus.rom_output_enable = 1'b0;
    bus.rom_address       = 32'h0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_base_next  = bus.pc;
          w_instr_next = 32'h0;
          w_error_next = 1'b0;
          if (CHECK_ALIGN && (bus.pc[1:0] != 2'b00)) begin
            w_error_next = 1'b1;
            w_state_next = DONE;
          end else begin
            w_state_next = READ0;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        if (w_reading) begin
          bus.rom_output_enable = 1'b1;
          bus.rom_address       = r_base + {30'h0, w_byte_idx};
          // An out-of-range byte aborts the whole word; no partial result survives
          if (bus.rom_illegal_address) begin
            w_instr_next = 32'h0;
            w_error_next = 1'b1;
            w_state_next = DONE;
          end else begin
            w_instr_next[{w_byte_idx, 3'b000} +: 8] = bus.rom_read_data;
            w_state_next = w_read_next;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
    endcase
  end

  assign bus.instruction = r_instr;
  assign bus.fetch_error = r_error;
  assign bus.out_valid   = (r_state == DONE);
  assign bus.busy        = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Function : Directed vector bench for instruction_fetch_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if ifa ();
  instruction_fetch_unit_if ifu ();

  instruction_fetch_unit #(.CHECK_ALIGN(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  instruction_fetch_unit #(.CHECK_ALIGN(1'b0)) dut_u (.clk(clk), .reset(reset), .bus(ifu));

  int errors = 0;
  int checks = 0;

  // ROM: 2048 bytes; 0x10..0x13 hold 93 00 50 00, elsewhere byte = addr*7+3
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    logic [31:0] t;
    case (a)
      32'h10:  return 8'h93;
      32'h11:  return 8'h00;
      32'h12:  return 8'h50;
      32'h13:  return 8'h00;
      default: begin t = a * 32'd7 + 32'd3; return t[7:0]; end
    endcase
  endfunction

  always_comb begin
    ifa.rom_illegal_address = ifa.rom_output_enable && (ifa.rom_address >= 32'h800);
    ifa.rom_read_data       = ifa.rom_illegal_address ? 8'h00 : rom_byte(ifa.rom_address);
    ifu.rom_illegal_address = ifu.rom_output_enable && (ifu.rom_address >= 32'h800);
    ifu.rom_read_data       = ifu.rom_illegal_address ? 8'h00 : rom_byte(ifu.rom_address);
  end

  logic [31:0] a_reads[$];
  logic [31:0] u_reads[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Record ROM reads; address must be zero whenever the enable is low
  always @(negedge clk) begin
    if (ifa.rom_output_enable) a_reads.push_back(ifa.rom_address);
    else if (ifa.rom_address !== 32'h0) check("a_idle_addr", ifa.rom_address, 32'h0);
    if (ifu.rom_output_enable) u_reads.push_back(ifu.rom_address);
    else if (ifu.rom_address !== 32'h0) check("u_idle_addr", ifu.rom_address, 32'h0);
  end

  function automatic logic get_valid(input bit u);
    return u ? ifu.out_valid : ifa.out_valid;
  endfunction

  typedef struct {
    bit          use_u;
    logic [31:0] pc;
    logic [31:0] exp_instr;
    logic        exp_err;
    int          exp_lat;
    int          exp_reads;
  } vec_t;

  vec_t vecs[$];

  // One fetch: start sampled at edge k, latency counted in cycles after k
  task automatic run_fetch(input vec_t v, input int hold_cycles);
    int n;
    logic [31:0] held;
    a_reads.delete();
    u_reads.delete();
    @(posedge clk); #1;
    if (v.use_u) begin ifu.start = 1'b1; ifu.pc = v.pc; end
    else         begin ifa.start = 1'b1; ifa.pc = v.pc; end
    @(posedge clk); #1;
    ifa.start = 1'b0; ifu.start = 1'b0;
    ifa.pc = 32'hDEAD_BEEF; ifu.pc = 32'hDEAD_BEEF;
    n = 1;
    @(negedge clk);
    while (!get_valid(v.use_u) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("latency pc=%h", v.pc), n, v.exp_lat);
    if (v.use_u) begin
      check($sformatf("instr pc=%h", v.pc), ifu.instruction, v.exp_instr);
      check($sformatf("err pc=%h", v.pc), {31'h0, ifu.fetch_error}, {31'h0, v.exp_err});
      check($sformatf("nreads pc=%h", v.pc), u_reads.size(), v.exp_reads);
      for (int i = 0; i < u_reads.size(); i++)
        check($sformatf("read%0d pc=%h", i, v.pc), u_reads[i], v.pc + i);
      held = ifu.instruction;
    end else begin
      check($sformatf("instr pc=%h", v.pc), ifa.instruction, v.exp_instr);
      check($sformatf("err pc=%h", v.pc), {31'h0, ifa.fetch_error}, {31'h0, v.exp_err});
      check($sformatf("nreads pc=%h", v.pc), a_reads.size(), v.exp_reads);
      for (int i = 0; i < a_reads.size(); i++)
        check($sformatf("read%0d pc=%h", i, v.pc), a_reads[i], v.pc + i);
      held = ifa.instruction;
    end
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check("hold_valid", {31'h0, get_valid(v.use_u)}, 32'h1);
      check("hold_instr", v.use_u ? ifu.instruction : ifa.instruction, held);
    end
    if (v.use_u) ifu.out_ready = 1'b1; else ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0; ifu.out_ready = 1'b0;
    @(negedge clk);
    check("busy_after_consume", {31'h0, v.use_u ? ifu.busy : ifa.busy}, 32'h0);
    check("valid_after_consume", {31'h0, get_valid(v.use_u)}, 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {31'h0, ifa.out_valid}, 32'h0);
    check({tag, "_busy"},  {31'h0, ifa.busy}, 32'h0);
    check({tag, "_err"},   {31'h0, ifa.fetch_error}, 32'h0);
    check({tag, "_instr"}, ifa.instruction, 32'h0);
    check({tag, "_oe"},    {31'h0, ifa.rom_output_enable}, 32'h0);
    check({tag, "_addr"},  ifa.rom_address, 32'h0);
  endtask

  initial begin
    int vo [$];
    int idle_cyc [$];
    vec_t v;
    ifa.start = 1'b0; ifa.pc = 32'h0; ifa.out_ready = 1'b0;
    ifu.start = 1'b0; ifu.pc = 32'h0; ifu.out_ready = 1'b0;

    vecs = '{
      '{1'b0, 32'h0000_0010, 32'h0050_0093, 1'b0, 5, 4},
      '{1'b0, 32'h0000_0020, 32'hF8F1_EAE3, 1'b0, 5, 4},
      '{1'b0, 32'h0000_0040, 32'hD8D1_CAC3, 1'b0, 5, 4},
      '{1'b0, 32'h0000_07FC, 32'hFCF5_EEE7, 1'b0, 5, 4},
      '{1'b0, 32'h0000_0006, 32'h0000_0000, 1'b1, 1, 0},
      '{1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1, 1, 0},
      '{1'b0, 32'h0000_0800, 32'h0000_0000, 1'b1, 2, 1},
      '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 2, 1},
      '{1'b1, 32'h0000_07FE, 32'h0000_0000, 1'b1, 4, 3},
      '{1'b1, 32'h0000_0011, 32'h8F00_5000, 1'b0, 5, 4}
    };

    // Start held during reset must be ignored
    ifa.start = 1'b1; ifa.pc = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    reset = 1'b0; ifa.start = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_fetch(vecs[i], 0);

    // Result held across three stalled cycles, consumed on the fourth
    v = vecs[0];
    run_fetch(v, 3);

    // Reset during READ2 of a fetch from 0x20
    @(posedge clk); #1;
    ifa.start = 1'b1; ifa.pc = 32'h20;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (3) @(negedge clk);
    check("in_read2_addr", ifa.rom_address, 32'h22);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    repeat (6) begin
      @(negedge clk);
      check("no_valid_after_reset", {31'h0, ifa.out_valid}, 32'h0);
    end
    run_fetch(vecs[0], 0);

    // Start held continuously across two back-to-back fetches
    @(posedge clk); #1;
    ifa.start = 1'b1; ifa.pc = 32'h10; ifa.out_ready = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (ifa.out_valid) vo.push_back(n);
      if (!ifa.busy) idle_cyc.push_back(n);
      if (n == 7) check("second_read0_addr", ifa.rom_address, 32'h10);
      if (n == 10) ifa.start = 1'b0;
    end
    check("b2b_nvalid", vo.size(), 2);
    if (vo.size() == 2) begin
      check("b2b_valid0", vo[0], 5);
      check("b2b_valid1", vo[1], 11);
    end
    check("b2b_nidle", idle_cyc.size(), 1);
    if (idle_cyc.size() == 1) check("b2b_idle_cycle", idle_cyc[0], 6);
    check("b2b_instr", ifa.instruction, 32'h0050_0093);
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    @(negedge clk);
    check("b2b_final_idle", {31'h0, ifa.busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
